// File: rtl/subtrator_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package subtrator_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/subtratorcompleto_struct.sv
// Single-bit full subtractor cell: diff = a - b - borrow_in.
// Ports:
//   a, b        operand bits
//   borrow_in   incoming borrow
//   diff        difference bit
//   borrow_out  outgoing borrow
module subtratorcompleto_struct (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic a_xor_b;

  assign a_xor_b    = a ^ b;
  assign diff       = a_xor_b ^ borrow_in;
  // Borrow when b exceeds a, or when they match and a borrow is pending.
  assign borrow_out = (~a & b) | (~a_xor_b & borrow_in);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit unsigned subtractor, LSB first, one full-subtractor cell.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       request pulse, honoured only in IDLE
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while bits are being processed
//   done        one-cycle pulse when diff/borrow_out are final
//   diff        a - b mod 2^N, held until the next operation completes
//   borrow_out  final borrow, 1 iff a < b
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int unsigned CW = $clog2(N);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  res;
  logic          borrow_q;
  logic [CW-1:0] count;
  logic          last_bit;
  logic          cell_diff;
  logic          cell_borrow;

  assign last_bit = (count == CW'(N - 1));

  // The only subtraction logic: one cell fed from the operand LSBs.
  subtratorcompleto_struct u_cell (
    .a          (sa[0]),
    .b          (sb[0]),
    .borrow_in  (borrow_q),
    .diff       (cell_diff),
    .borrow_out (cell_borrow)
  );

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with busy/done registered alongside as state decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == SHIFT);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: operand shifters, borrow flop, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      borrow_q   <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sa       <= a;
      sb       <= b;
      res      <= '0;
      borrow_q <= 1'b0;
      count    <= '0;
    end else if (state == SHIFT) begin
      // Right shift with new bit at MSB: bit i settles at position i after N shifts.
      res      <= {cell_diff, res[N-1:1]};
      borrow_q <= cell_borrow;
      sa       <= sa >> 1;
      sb       <= sb >> 1;
      count    <= count + CW'(1);
      if (last_bit) begin
        diff       <= {cell_diff, res[N-1:1]};
        borrow_out <= cell_borrow;
      end
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial at N=8 and N=13.
module tb_subtrator_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, busy8, done8, bo8;
  logic [7:0]  a8, b8, diff8;
  logic        rst13, start13, busy13, done13, bo13;
  logic [12:0] a13, b13, diff13;

  int n_chk  = 0;
  int n_fail = 0;
  bit en     = 1'b0;
  bit fin13  = 1'b0;

  subtrator_serial #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  subtrator_serial #(.N(13)) dut13 (
    .clk(clk), .rst(rst13), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: remaining busy cycles, pending result, done flag.
  int m8_rem, m8_diff, p8_diff;
  bit m8_done, m8_bo, p8_bo;
  always @(posedge clk) begin
    if (rst8) begin
      m8_rem <= 0; m8_done <= 1'b0; m8_diff <= 0; m8_bo <= 1'b0;
    end else if (m8_done) begin
      m8_done <= 1'b0;
    end else if (m8_rem == 0) begin
      if (start8) begin
        m8_rem  <= 8;
        p8_diff <= (int'(a8) - int'(b8)) & 32'hFF;
        p8_bo   <= (a8 < b8);
      end
    end else if (m8_rem == 1) begin
      m8_rem <= 0; m8_done <= 1'b1; m8_diff <= p8_diff; m8_bo <= p8_bo;
    end else begin
      m8_rem <= m8_rem - 1;
    end
  end

  int m13_rem, m13_diff, p13_diff;
  bit m13_done, m13_bo, p13_bo;
  always @(posedge clk) begin
    if (rst13) begin
      m13_rem <= 0; m13_done <= 1'b0; m13_diff <= 0; m13_bo <= 1'b0;
    end else if (m13_done) begin
      m13_done <= 1'b0;
    end else if (m13_rem == 0) begin
      if (start13) begin
        m13_rem  <= 13;
        p13_diff <= (int'(a13) - int'(b13)) & 32'h1FFF;
        p13_bo   <= (a13 < b13);
      end
    end else if (m13_rem == 1) begin
      m13_rem <= 0; m13_done <= 1'b1; m13_diff <= p13_diff; m13_bo <= p13_bo;
    end else begin
      m13_rem <= m13_rem - 1;
    end
  end

  // Cycle-by-cycle comparison against the models.
  always @(negedge clk) begin
    if (en) begin
      check("busy8",  32'(busy8), 32'(m8_rem != 0));
      check("done8",  32'(done8), 32'(m8_done));
      check("diff8",  32'(diff8), m8_diff);
      check("bo8",    32'(bo8),   32'(m8_bo));
      check("busy13", 32'(busy13), 32'(m13_rem != 0));
      check("done13", 32'(done13), 32'(m13_done));
      check("diff13", 32'(diff13), m13_diff);
      check("bo13",   32'(bo13),   32'(m13_bo));
    end
  end

  // kind: 0 plain, 1 extra start at cycle 'at', 2 reset at cycle 'at'.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int kind, input int at,
                     input int exp_d, input bit exp_bo, input bit exp_seen);
    int lat;
    bit seen;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      if (kind == 1 && lat == at) begin
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd9;
      end else if (kind == 2 && lat == at) begin
        rst8 = 1'b1;
      end else begin
        start8 = 1'b0; rst8 = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done8) seen = 1'b1;
    end
    start8 = 1'b0; rst8 = 1'b0;
    check("op8_done_seen", 32'(seen), 32'(exp_seen));
    if (exp_seen) check("op8_latency", lat, 8);
    check("op8_diff", 32'(diff8), exp_d);
    check("op8_borrow", 32'(bo8), 32'(exp_bo));
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input int exp_d, input bit exp_bo);
    int lat;
    @(negedge clk);
    a13 = a; b13 = b; start13 = 1'b1;
    @(negedge clk);
    start13 = 1'b0;
    lat = 0;
    while (lat < 30 && !done13) begin
      @(negedge clk);
      lat++;
    end
    check("op13_latency", lat, 13);
    check("op13_diff", 32'(diff13), exp_d);
    check("op13_borrow", 32'(bo13), 32'(exp_bo));
  endtask

  initial begin
    logic [12:0] ra, rb;
    rst13 = 1'b1; start13 = 1'b0; a13 = '0; b13 = '0;
    repeat (2) @(negedge clk);
    rst13 = 1'b0;
    op13(13'd0, 13'd8191, 1, 1'b1);
    op13(13'd8191, 13'd0, 8191, 1'b0);
    op13(13'd5000, 13'd1234, 3766, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = 13'($urandom_range(0, 8191));
      rb = 13'($urandom_range(0, 8191));
      op13(ra, rb, (int'(ra) - int'(rb)) & 32'h1FFF, ra < rb);
    end
    fin13 = 1'b1;
  end

  initial begin
    logic [7:0] ra, rb;
    int wait_cnt;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    rst8 = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy8), 0);
    check("idle_done", 32'(done8), 0);
    check("idle_diff", 32'(diff8), 0);
    check("idle_borrow", 32'(bo8), 0);

    op8(8'd100, 8'd37,  0, 0, 63,  1'b0, 1'b1);
    op8(8'd5,   8'd10,  0, 0, 251, 1'b1, 1'b1);
    op8(8'd0,   8'd1,   0, 0, 255, 1'b1, 1'b1);
    op8(8'd255, 8'd255, 0, 0, 0,   1'b0, 1'b1);
    op8(8'd200, 8'd1,   1, 3, 199, 1'b0, 1'b1);
    op8(8'd50,  8'd20,  2, 4, 0,   1'b0, 1'b0);
    op8(8'd9,   8'd4,   0, 0, 5,   1'b0, 1'b1);
    op8(8'd128, 8'd129, 0, 0, 255, 1'b1, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, 0, 0, (int'(ra) - int'(rb)) & 32'hFF, ra < rb, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_cnt = 0;
    while (!fin13 && wait_cnt < 50000) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("n13_finished", 32'(fin13), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
